// File: rtl/decrypt_out_pkg.sv
// Shared types for the decrypt output stage: the word geometry and the FIFO entry
// that carries a packed word with its count of valid bytes.
package decrypt_out_pkg;
    localparam int WORD_W         = 32;
    localparam int BYTES_PER_WORD = 4;

    typedef logic [2:0] nbytes_t;

    typedef struct packed {
        nbytes_t           nbytes;
        logic [WORD_W-1:0] data;
    } out_word_t;
endpackage

// File: rtl/decrypt_out_fifo.sv
// Synchronous show-ahead FIFO of out_word_t. The head entry is presented
// combinationally, and it reads as all-zero whenever the FIFO is empty.
module decrypt_out_fifo
    import decrypt_out_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  out_word_t              wdata,
    input  logic                   pop,
    output out_word_t              rdata,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    out_word_t       mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic            do_push;
    logic            do_pop;

    assign full  = (level == LW'(DEPTH));
    assign empty = (level == '0);

    // A pop frees a slot in the same cycle, so a push into a full FIFO can still land.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    assign rdata = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push && !rst) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end
endmodule

// File: rtl/decrypt_out_packer.sv
// Packs the decrypt pipeline's byte stream little-endian into 32-bit words and
// queues them for a consumer; words that find the queue full are dropped and flagged.
module decrypt_out_packer
    import decrypt_out_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   v_in,
    input  logic [7:0]             din,
    input  logic                   flush,
    input  logic                   out_ready,
    input  logic                   clr_ovf,
    output logic                   out_valid,
    output logic [WORD_W-1:0]      out_data,
    output logic [2:0]             out_nbytes,
    output logic                   overflow,
    output logic [$clog2(DEPTH):0] level
);
    logic [1:0]  cnt;
    logic [23:0] pack;
    logic [1:0]  cnt_nx;
    logic [23:0] pack_nx;
    logic        push_req;
    out_word_t   push_word;
    out_word_t   head;
    logic        fifo_full;
    logic        fifo_empty;
    logic        pop;
    logic        drop;

    // Output handshake: a word transfers on a rising edge where out_valid && out_ready;
    // out_valid never waits on out_ready, and the head holds steady until it is taken.
    assign pop = out_valid && out_ready;

    // pack is cleared whenever a word leaves, so lanes above cnt always read as zero.
    always_comb begin
        cnt_nx    = cnt;
        pack_nx   = pack;
        push_req  = 1'b0;
        push_word = '0;
        if (v_in) begin
            if (cnt == 2'd3) begin
                push_req         = 1'b1;
                push_word.data   = {din, pack};
                push_word.nbytes = 3'd4;
                cnt_nx           = 2'd0;
                pack_nx          = '0;
            end else begin
                case (cnt)
                    2'd0:    pack_nx[7:0]   = din;
                    2'd1:    pack_nx[15:8]  = din;
                    default: pack_nx[23:16] = din;
                endcase
                cnt_nx = cnt + 2'd1;
            end
        end
        if (flush && !push_req && cnt_nx != 2'd0) begin
            push_req         = 1'b1;
            push_word.data   = {8'h00, pack_nx};
            push_word.nbytes = {1'b0, cnt_nx};
            cnt_nx           = 2'd0;
            pack_nx          = '0;
        end
    end

    assign drop = push_req && fifo_full && !pop;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt      <= '0;
            pack     <= '0;
            overflow <= 1'b0;
        end else begin
            cnt  <= cnt_nx;
            pack <= pack_nx;
            if (drop)         overflow <= 1'b1;
            else if (clr_ovf) overflow <= 1'b0;
        end
    end

    decrypt_out_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push_req),
        .wdata (push_word),
        .pop   (pop),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (level)
    );

    assign out_valid  = !fifo_empty;
    assign out_data   = head.data;
    assign out_nbytes = head.nbytes;
endmodule

// File: tb/tb_decrypt_out_packer.sv
// Directed bench for decrypt_out_packer: packing, flush, overflow, full+pop and reset.
module tb_decrypt_out_packer;
    localparam int DEPTH = 8;

    logic        clk;
    logic        rst;
    logic        v_in;
    logic [7:0]  din;
    logic        flush;
    logic        out_ready;
    logic        clr_ovf;
    logic        out_valid;
    logic [31:0] out_data;
    logic [2:0]  out_nbytes;
    logic        overflow;
    logic [3:0]  level;

    int pass_cnt  = 0;
    int total_cnt = 0;
    logic [31:0] exp_q[$];

    decrypt_out_packer #(.DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .v_in       (v_in),
        .din        (din),
        .flush      (flush),
        .out_ready  (out_ready),
        .clr_ovf    (clr_ovf),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_nbytes (out_nbytes),
        .overflow   (overflow),
        .level      (level)
    );

    // clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // driver tasks: inputs change 1 time unit after the rising edge, checks sample there too
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic f);
        v_in  = 1'b1;
        din   = b;
        flush = f;
        tick();
        v_in  = 1'b0;
        din   = 8'h00;
        flush = 1'b0;
    endtask

    task automatic do_flush();
        flush = 1'b1;
        tick();
        flush = 1'b0;
    endtask

    task automatic pop_one();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act !== exp) $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        else pass_cnt++;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        chk("reset out_valid", 32'(out_valid), 32'd0);
        chk("reset out_data", out_data, 32'd0);
        chk("reset out_nbytes", 32'(out_nbytes), 32'd0);
        chk("reset level", 32'(level), 32'd0);
        chk("reset overflow", 32'(overflow), 32'd0);
    endtask

    task automatic test_basic_pack();
        logic [7:0] bytes [8];
        bytes = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            send_byte(bytes[i], 1'b0);
            if (i == 3) begin
                chk("basic w0 valid", 32'(out_valid), 32'd1);
                chk("basic w0 data", out_data, 32'h44332211);
                chk("basic w0 nbytes", 32'(out_nbytes), 32'd4);
            end else if (i == 7) begin
                chk("basic w1 valid", 32'(out_valid), 32'd1);
                chk("basic w1 data", out_data, 32'h88776655);
                chk("basic w1 nbytes", 32'(out_nbytes), 32'd4);
            end else begin
                out_ready = 1'b1;
                chk("basic idle valid", 32'(out_valid), 32'd0);
            end
        end
        tick();
        out_ready = 1'b0;
        chk("basic drained level", 32'(level), 32'd0);
        chk("basic drained valid", 32'(out_valid), 32'd0);
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        send_byte(8'hA1, 1'b0);
        send_byte(8'hB2, 1'b0);
        chk("flush before level", 32'(level), 32'd0);
        do_flush();
        chk("flush partial valid", 32'(out_valid), 32'd1);
        chk("flush partial data", out_data, 32'h0000B2A1);
        chk("flush partial nbytes", 32'(out_nbytes), 32'd2);
        chk("flush partial level", 32'(level), 32'd1);
        do_flush();
        chk("flush empty level", 32'(level), 32'd1);
        pop_one();
        chk("flush popped level", 32'(level), 32'd0);
        chk("flush popped nbytes", 32'(out_nbytes), 32'd0);
    endtask

    task automatic test_flush_same_cycle();
        out_ready = 1'b0;
        send_byte(8'h01, 1'b0);
        send_byte(8'h02, 1'b0);
        send_byte(8'h03, 1'b0);
        send_byte(8'h04, 1'b1);
        chk("flush+byte level", 32'(level), 32'd1);
        chk("flush+byte data", out_data, 32'h04030201);
        chk("flush+byte nbytes", 32'(out_nbytes), 32'd4);
        pop_one();
        chk("flush+byte one word", 32'(level), 32'd0);
        // a single leftover byte flushed alone pads three zero lanes
        send_byte(8'h5A, 1'b1);
        chk("flush one byte data", out_data, 32'h0000005A);
        chk("flush one byte nbytes", 32'(out_nbytes), 32'd1);
        pop_one();
    endtask

    task automatic test_overflow();
        out_ready = 1'b0;
        exp_q.delete();
        for (int i = 0; i < 40; i++) begin
            send_byte(8'(i), 1'b0);
            if (i == 31) begin
                chk("ovf full level", 32'(level), 32'd8);
                chk("ovf not yet set", 32'(overflow), 32'd0);
            end
        end
        chk("ovf level", 32'(level), 32'd8);
        chk("ovf flag", 32'(overflow), 32'd1);
        for (int k = 0; k < 8; k++) begin
            exp_q.push_back({8'(4*k+3), 8'(4*k+2), 8'(4*k+1), 8'(4*k)});
        end
        while (exp_q.size() > 0) begin
            chk("ovf drain valid", 32'(out_valid), 32'd1);
            chk("ovf drain data", out_data, exp_q.pop_front());
            pop_one();
        end
        chk("ovf drained level", 32'(level), 32'd0);
        chk("ovf sticky", 32'(overflow), 32'd1);
        clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;
        chk("ovf cleared", 32'(overflow), 32'd0);
    endtask

    task automatic test_full_pop();
        out_ready = 1'b0;
        exp_q.delete();
        for (int i = 0; i < 32; i++) send_byte(8'(8'h40 + i), 1'b0);
        chk("fullpop level full", 32'(level), 32'd8);
        send_byte(8'hC0, 1'b0);
        send_byte(8'hC1, 1'b0);
        send_byte(8'hC2, 1'b0);
        out_ready = 1'b1;
        send_byte(8'hC3, 1'b0);
        out_ready = 1'b0;
        chk("fullpop level held", 32'(level), 32'd8);
        chk("fullpop no overflow", 32'(overflow), 32'd0);
        for (int k = 1; k < 8; k++) begin
            exp_q.push_back({8'(8'h40 + 4*k+3), 8'(8'h40 + 4*k+2), 8'(8'h40 + 4*k+1), 8'(8'h40 + 4*k)});
        end
        exp_q.push_back(32'hC3C2C1C0);
        while (exp_q.size() > 0) begin
            chk("fullpop drain data", out_data, exp_q.pop_front());
            pop_one();
        end
        chk("fullpop drained valid", 32'(out_valid), 32'd0);
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        for (int i = 0; i < 11; i++) send_byte(8'(8'h90 + i), 1'b0);
        chk("rstmid queued", 32'(level), 32'd2);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rstmid valid", 32'(out_valid), 32'd0);
        chk("rstmid level", 32'(level), 32'd0);
        chk("rstmid overflow", 32'(overflow), 32'd0);
        send_byte(8'hD0, 1'b0);
        send_byte(8'hD1, 1'b0);
        send_byte(8'hD2, 1'b0);
        send_byte(8'hD3, 1'b0);
        chk("rstmid fresh data", out_data, 32'hD3D2D1D0);
        chk("rstmid fresh nbytes", 32'(out_nbytes), 32'd4);
        chk("rstmid fresh level", 32'(level), 32'd1);
    endtask

    initial begin
        rst       = 1'b1;
        v_in      = 1'b0;
        din       = 8'h00;
        flush     = 1'b0;
        out_ready = 1'b0;
        clr_ovf   = 1'b0;
        test_reset();
        test_basic_pack();
        test_flush();
        test_flush_same_cycle();
        test_overflow();
        test_full_pop();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
